// File: rtl/ctrl_decode_queue_if.sv
// Fetch-side and issue-side signals of the decode queue, plus the decoded
// control bundle presented with the head entry.
interface ctrl_decode_queue_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        reg_write;
  logic        alu_src;
  logic        mem_write;
  logic        mem_read;
  logic        branch;
  logic        jump;
  logic        csr;
  logic        fence;
  logic [1:0]  result_src;
  logic [2:0]  imm_src;
  logic [1:0]  alu_op;
  logic        is_fpu;
  logic        fp_reg_write;
  logic        fp_mem_read;
  logic        fp_mem_write;
  logic        is_amo;
  logic        illegal;

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_instr, out_pc,
    output reg_write, alu_src, mem_write, mem_read, branch, jump, csr, fence,
    output result_src, imm_src, alu_op,
    output is_fpu, fp_reg_write, fp_mem_read, fp_mem_write, is_amo, illegal
  );

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_instr, out_pc,
    input  reg_write, alu_src, mem_write, mem_read, branch, jump, csr, fence,
    input  result_src, imm_src, alu_op,
    input  is_fpu, fp_reg_write, fp_mem_read, fp_mem_write, is_amo, illegal
  );
endinterface

// File: rtl/ctrl_decode_queue.sv
// RV32IMFA decode stage: opcodes are decoded at enqueue time and the control
// bundle is stored with the instruction in a DEPTH-entry FIFO.
module ctrl_decode_queue #(
  parameter int DEPTH = 4,
  parameter bit EN_F  = 1'b1,
  parameter bit EN_A  = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     fpu_busy,
  output logic [$clog2(DEPTH):0]   count,
  ctrl_decode_queue_if.slave       q
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_MISC   = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_FLW    = 7'b0000111;
  localparam logic [6:0] OP_FSW    = 7'b0100111;
  localparam logic [6:0] OP_FMADD  = 7'b1000011;
  localparam logic [6:0] OP_FMSUB  = 7'b1000111;
  localparam logic [6:0] OP_FNMSUB = 7'b1001011;
  localparam logic [6:0] OP_FNMADD = 7'b1001111;
  localparam logic [6:0] OP_FOP    = 7'b1010011;
  localparam logic [6:0] OP_AMO    = 7'b0101111;

  typedef struct packed {
    logic       reg_write;
    logic       alu_src;
    logic       mem_write;
    logic       mem_read;
    logic       branch;
    logic       jump;
    logic       csr;
    logic       fence;
    logic [1:0] result_src;
    logic [2:0] imm_src;
    logic [1:0] alu_op;
    logic       is_fpu;
    logic       fp_reg_write;
    logic       fp_mem_read;
    logic       fp_mem_write;
    logic       is_amo;
    logic       illegal;
  } ctrl_t;

  ctrl_t dec;

  // Any opcode with in_instr[1:0] != 2'b11 misses every arm and lands in default.
  always_comb begin
    dec = '0;
    case (q.in_instr[6:0])
      OP_LUI, OP_AUIPC: begin
        dec.reg_write = 1'b1; dec.alu_src = 1'b1;
        dec.imm_src = 3'b011; dec.result_src = 2'b11;
      end
      OP_JAL: begin
        dec.reg_write = 1'b1; dec.jump = 1'b1;
        dec.imm_src = 3'b100; dec.result_src = 2'b10;
      end
      OP_JALR: begin
        dec.reg_write = 1'b1; dec.jump = 1'b1;
        dec.alu_src = 1'b1; dec.result_src = 2'b10;
      end
      OP_BRANCH: begin
        dec.branch = 1'b1; dec.imm_src = 3'b010; dec.alu_op = 2'b01;
      end
      OP_LOAD: begin
        dec.reg_write = 1'b1; dec.alu_src = 1'b1;
        dec.mem_read = 1'b1; dec.result_src = 2'b01;
      end
      OP_STORE: begin
        dec.alu_src = 1'b1; dec.mem_write = 1'b1; dec.imm_src = 3'b001;
      end
      OP_IMM: begin
        dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.alu_op = 2'b10;
      end
      OP_OP: begin
        dec.reg_write = 1'b1; dec.alu_op = 2'b10;
      end
      OP_MISC:   dec.fence = 1'b1;
      OP_SYSTEM: dec.csr = 1'b1;
      OP_FLW: begin
        if (EN_F) begin
          dec.is_fpu = 1'b1; dec.fp_reg_write = 1'b1;
          dec.fp_mem_read = 1'b1; dec.alu_src = 1'b1;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OP_FSW: begin
        if (EN_F) begin
          dec.is_fpu = 1'b1; dec.fp_mem_write = 1'b1;
          dec.alu_src = 1'b1; dec.imm_src = 3'b001;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OP_FMADD, OP_FMSUB, OP_FNMSUB, OP_FNMADD, OP_FOP: begin
        if (EN_F) begin
          dec.is_fpu = 1'b1; dec.fp_reg_write = 1'b1;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OP_AMO: begin
        if (EN_A) begin
          dec.is_amo = 1'b1; dec.reg_write = 1'b1; dec.mem_read = 1'b1;
          dec.mem_write = 1'b1; dec.result_src = 2'b01;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  ctrl_t       ctrl_mem  [DEPTH];
  logic [31:0] instr_mem [DEPTH];
  logic [31:0] pc_mem    [DEPTH];

  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;

  logic  empty;
  logic  full;
  logic  enq;
  logic  deq;
  logic  head_valid;
  ctrl_t head;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == CNT_W'(DEPTH));

  // in_ready depends only on registered occupancy, never on out_ready.
  assign enq        = q.in_valid && !full && !flush;
  assign head       = empty ? '0 : ctrl_mem[rd_ptr_reg];
  assign head_valid = !empty && !(head.is_fpu && fpu_busy);
  assign deq        = head_valid && q.out_ready && !flush;

  always_ff @(posedge clk) begin
    if (enq) begin
      ctrl_mem[wr_ptr_reg]  <= dec;
      instr_mem[wr_ptr_reg] <= q.in_instr;
      pc_mem[wr_ptr_reg]    <= q.in_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (enq) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (deq) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({enq, deq})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign count          = count_reg;
  assign q.in_ready     = !full;
  assign q.out_valid    = head_valid;
  assign q.out_instr    = empty ? 32'd0 : instr_mem[rd_ptr_reg];
  assign q.out_pc       = empty ? 32'd0 : pc_mem[rd_ptr_reg];
  assign q.reg_write    = head.reg_write;
  assign q.alu_src      = head.alu_src;
  assign q.mem_write    = head.mem_write;
  assign q.mem_read     = head.mem_read;
  assign q.branch       = head.branch;
  assign q.jump         = head.jump;
  assign q.csr          = head.csr;
  assign q.fence        = head.fence;
  assign q.result_src   = head.result_src;
  assign q.imm_src      = head.imm_src;
  assign q.alu_op       = head.alu_op;
  assign q.is_fpu       = head.is_fpu;
  assign q.fp_reg_write = head.fp_reg_write;
  assign q.fp_mem_read  = head.fp_mem_read;
  assign q.fp_mem_write = head.fp_mem_write;
  assign q.is_amo       = head.is_amo;
  assign q.illegal      = head.illegal;
endmodule

// File: tb/tb_ctrl_decode_queue.sv
// Bench for ctrl_decode_queue: decode vector table, directed queue corner
// cases, and randomized traffic against a queue-based reference model.
module tb_ctrl_decode_queue;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       flush;
  logic       fpu_busy;
  logic [2:0] count;
  logic [2:0] count_n;

  ctrl_decode_queue_if ifc ();
  ctrl_decode_queue_if ifn ();

  ctrl_decode_queue #(.DEPTH(DEPTH), .EN_F(1'b1), .EN_A(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .fpu_busy(fpu_busy),
    .count(count), .q(ifc)
  );

  ctrl_decode_queue #(.DEPTH(DEPTH), .EN_F(1'b0), .EN_A(1'b0)) dut_n (
    .clk(clk), .rst(rst), .flush(flush), .fpu_busy(fpu_busy),
    .count(count_n), .q(ifn)
  );

  // Bundle bit positions, MSB first: reg_write alu_src mem_write mem_read
  // branch jump csr fence result_src[2] imm_src[3] alu_op[2] is_fpu
  // fp_reg_write fp_mem_read fp_mem_write is_amo illegal
  wire [20:0] act = {ifc.reg_write, ifc.alu_src, ifc.mem_write, ifc.mem_read,
                     ifc.branch, ifc.jump, ifc.csr, ifc.fence, ifc.result_src,
                     ifc.imm_src, ifc.alu_op, ifc.is_fpu, ifc.fp_reg_write,
                     ifc.fp_mem_read, ifc.fp_mem_write, ifc.is_amo, ifc.illegal};
  wire [20:0] act_n = {ifn.reg_write, ifn.alu_src, ifn.mem_write, ifn.mem_read,
                       ifn.branch, ifn.jump, ifn.csr, ifn.fence, ifn.result_src,
                       ifn.imm_src, ifn.alu_op, ifn.is_fpu, ifn.fp_reg_write,
                       ifn.fp_mem_read, ifn.fp_mem_write, ifn.is_amo, ifn.illegal};

  localparam logic [20:0] RW  = 21'd1 << 20;
  localparam logic [20:0] AS  = 21'd1 << 19;
  localparam logic [20:0] MW  = 21'd1 << 18;
  localparam logic [20:0] MR  = 21'd1 << 17;
  localparam logic [20:0] BR  = 21'd1 << 16;
  localparam logic [20:0] JP  = 21'd1 << 15;
  localparam logic [20:0] CS  = 21'd1 << 14;
  localparam logic [20:0] FE  = 21'd1 << 13;
  localparam logic [20:0] FPU = 21'd1 << 5;
  localparam logic [20:0] FRW = 21'd1 << 4;
  localparam logic [20:0] FMR = 21'd1 << 3;
  localparam logic [20:0] FMW = 21'd1 << 2;
  localparam logic [20:0] AMO = 21'd1 << 1;
  localparam logic [20:0] ILL = 21'd1;

  function automatic logic [20:0] rs(input int v); return 21'(v) << 11; endfunction
  function automatic logic [20:0] is(input int v); return 21'(v) << 8;  endfunction
  function automatic logic [20:0] ao(input int v); return 21'(v) << 6;  endfunction

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h required %h", name, got, want);
  endtask

  // Reference decode: opcode lookup table with an extension tag (0 base, 1 F, 2 A).
  typedef struct { logic [6:0] op; logic [20:0] b; int ext; } ref_t;
  ref_t ref_tab [19];

  function automatic logic [20:0] ref_decode(input logic [31:0] instr, input bit en_f, input bit en_a);
    for (int k = 0; k < 19; k++) begin
      if (ref_tab[k].op == instr[6:0]) begin
        if ((ref_tab[k].ext == 1 && !en_f) || (ref_tab[k].ext == 2 && !en_a)) return ILL;
        return ref_tab[k].b;
      end
    end
    return ILL;
  endfunction

  typedef struct { logic [31:0] instr; logic [20:0] exp; } vec_t;
  vec_t vecs [19];

  typedef struct { logic [31:0] instr; logic [31:0] pc; logic [20:0] b; } ent_t;
  ent_t mq [$];

  task automatic tick(); @(posedge clk); #1; endtask

  task automatic idle_inputs();
    ifc.in_valid = 1'b0; ifc.in_instr = '0; ifc.in_pc = '0; ifc.out_ready = 1'b0;
    ifn.in_valid = 1'b0; ifn.in_instr = '0; ifn.in_pc = '0; ifn.out_ready = 1'b0;
    flush = 1'b0; fpu_busy = 1'b0;
  endtask

  initial begin
    ref_tab[0]  = '{7'b0110111, RW | AS | is(3) | rs(3), 0};
    ref_tab[1]  = '{7'b0010111, RW | AS | is(3) | rs(3), 0};
    ref_tab[2]  = '{7'b1101111, RW | JP | is(4) | rs(2), 0};
    ref_tab[3]  = '{7'b1100111, RW | JP | AS | rs(2), 0};
    ref_tab[4]  = '{7'b1100011, BR | is(2) | ao(1), 0};
    ref_tab[5]  = '{7'b0000011, RW | AS | MR | rs(1), 0};
    ref_tab[6]  = '{7'b0100011, AS | MW | is(1), 0};
    ref_tab[7]  = '{7'b0010011, RW | AS | ao(2), 0};
    ref_tab[8]  = '{7'b0110011, RW | ao(2), 0};
    ref_tab[9]  = '{7'b0001111, FE, 0};
    ref_tab[10] = '{7'b1110011, CS, 0};
    ref_tab[11] = '{7'b0000111, FPU | FRW | FMR | AS, 1};
    ref_tab[12] = '{7'b0100111, FPU | FMW | AS | is(1), 1};
    ref_tab[13] = '{7'b1000011, FPU | FRW, 1};
    ref_tab[14] = '{7'b1000111, FPU | FRW, 1};
    ref_tab[15] = '{7'b1001011, FPU | FRW, 1};
    ref_tab[16] = '{7'b1001111, FPU | FRW, 1};
    ref_tab[17] = '{7'b1010011, FPU | FRW, 1};
    ref_tab[18] = '{7'b0101111, AMO | RW | MR | MW | rs(1), 2};

    vecs[0]  = '{32'h00B50533, RW | ao(2)};                 // ADD
    vecs[1]  = '{32'h12345037, RW | AS | is(3) | rs(3)};    // LUI
    vecs[2]  = '{32'h00001097, RW | AS | is(3) | rs(3)};    // AUIPC
    vecs[3]  = '{32'h008000EF, RW | JP | is(4) | rs(2)};    // JAL
    vecs[4]  = '{32'h00008067, RW | JP | AS | rs(2)};       // JALR
    vecs[5]  = '{32'h00B50463, BR | is(2) | ao(1)};         // BEQ
    vecs[6]  = '{32'h0002A303, RW | AS | MR | rs(1)};       // LW
    vecs[7]  = '{32'h0002A087, FPU | FRW | FMR | AS};       // FLW
    vecs[8]  = '{32'h00B5252F, AMO | RW | MR | MW | rs(1)}; // AMOADD
    vecs[9]  = '{32'h00B2A023, AS | MW | is(1)};            // SW
    vecs[10] = '{32'h00150513, RW | AS | ao(2)};            // ADDI
    vecs[11] = '{32'h0000000F, FE};                         // FENCE
    vecs[12] = '{32'h00000073, CS};                         // ECALL
    vecs[13] = '{32'h0012A027, FPU | FMW | AS | is(1)};     // FSW
    vecs[14] = '{32'h00B57043, FPU | FRW};                  // FMADD
    vecs[15] = '{32'h00B57053, FPU | FRW};                  // FADD
    vecs[16] = '{32'h00000000, ILL};
    vecs[17] = '{32'hFFFFFFFF, ILL};
    vecs[18] = '{32'h00B50530, ILL};                        // low bits 00

    idle_inputs();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    check("reset_count", 64'(count), 64'd0);
    check("reset_out_valid", 64'(ifc.out_valid), 64'd0);
    check("reset_in_ready", 64'(ifc.in_ready), 64'd1);
    check("reset_bundle", 64'(act), 64'd0);
    check("reset_out_instr", 64'(ifc.out_instr), 64'd0);

    // Decode table: each vector enqueued alone, checked at the head, dequeued.
    for (int i = 0; i < 19; i++) begin
      ifc.in_valid = 1'b1; ifc.in_instr = vecs[i].instr; ifc.in_pc = 32'h1000 + 32'(i * 4);
      ifn.in_valid = 1'b1; ifn.in_instr = vecs[i].instr; ifn.in_pc = 32'h1000 + 32'(i * 4);
      tick();
      ifc.in_valid = 1'b0; ifn.in_valid = 1'b0;
      #1;
      $display("vec %0d instr=%h bundle=%h bundle_noext=%h count=%0d",
               i, vecs[i].instr, act, act_n, count);
      check("vec_out_valid", 64'(ifc.out_valid), 64'd1);
      check("vec_count", 64'(count), 64'd1);
      check("vec_bundle", 64'(act), 64'(vecs[i].exp));
      check("vec_instr", 64'(ifc.out_instr), 64'(vecs[i].instr));
      check("vec_pc", 64'(ifc.out_pc), 64'(32'h1000 + 32'(i * 4)));
      check("vec_noext_bundle", 64'(act_n), 64'(ref_decode(vecs[i].instr, 1'b0, 1'b0)));
      ifc.out_ready = 1'b1; ifn.out_ready = 1'b1;
      tick();
      ifc.out_ready = 1'b0; ifn.out_ready = 1'b0;
      #1;
      check("vec_drained_count", 64'(count), 64'd0);
      check("vec_drained_bundle", 64'(act), 64'd0);
    end

    // With F and A disabled, FLW and the all-zero word decode to illegal only.
    ifn.in_valid = 1'b1; ifn.in_instr = 32'h0002A087;
    tick();
    ifn.in_instr = 32'h00000000;
    tick();
    ifn.in_valid = 1'b0;
    #1;
    $display("noext FLW head bundle=%h", act_n);
    check("noext_flw_illegal", 64'(act_n), 64'(ILL));
    ifn.out_ready = 1'b1;
    tick();
    ifn.out_ready = 1'b0;
    #1;
    $display("noext zero-word head bundle=%h", act_n);
    check("noext_zero_illegal", 64'(act_n), 64'(ILL));
    ifn.out_ready = 1'b1;
    tick();
    ifn.out_ready = 1'b0;
    #1;
    check("noext_drained", 64'(count_n), 64'd0);

    // Backpressure: 5 offers with out_ready low; the 5th waits.
    for (int k = 0; k < 5; k++) begin
      ifc.in_valid = 1'b1; ifc.in_instr = 32'h00000013 | (32'(k) << 20);
      ifc.in_pc = 32'h2000 + 32'(k * 4);
      tick();
      $display("push %0d count=%0d in_ready=%0d", k, count, ifc.in_ready);
    end
    check("full_count", 64'(count), 64'd4);
    check("full_in_ready", 64'(ifc.in_ready), 64'd0);
    ifc.out_ready = 1'b1;
    #1;
    check("full_head", 64'(ifc.out_instr), 64'(32'h00000013));
    check("full_in_ready_during_deq", 64'(ifc.in_ready), 64'd0);
    tick();
    ifc.out_ready = 1'b0;
    #1;
    check("after_pulse_count", 64'(count), 64'd3);
    check("after_pulse_in_ready", 64'(ifc.in_ready), 64'd1);
    tick();
    ifc.in_valid = 1'b0;
    #1;
    check("fifth_accepted", 64'(count), 64'd4);
    ifc.out_ready = 1'b1;
    for (int k = 1; k < 5; k++) begin
      #1;
      $display("pop instr=%h", ifc.out_instr);
      check("drain_order", 64'(ifc.out_instr), 64'(32'h00000013 | (32'(k) << 20)));
      tick();
    end
    ifc.out_ready = 1'b0;
    #1;
    check("drain_empty", 64'(count), 64'd0);

    // FP head held by fpu_busy for three cycles.
    ifc.in_valid = 1'b1; ifc.in_instr = 32'h00B57053; fpu_busy = 1'b1; ifc.out_ready = 1'b1;
    tick();
    ifc.in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      $display("fpu_busy cycle %0d out_valid=%0d", k, ifc.out_valid);
      check("fpu_blocked", 64'(ifc.out_valid), 64'd0);
      check("fpu_blocked_count", 64'(count), 64'd1);
      tick();
    end
    fpu_busy = 1'b0;
    #1;
    check("fpu_released", 64'(ifc.out_valid), 64'd1);
    check("fpu_is_fpu", 64'(ifc.is_fpu), 64'd1);
    tick();
    ifc.out_ready = 1'b0;
    #1;
    check("fpu_dequeued", 64'(count), 64'd0);

    // Flush with three entries and a same-cycle offer.
    for (int k = 0; k < 3; k++) begin
      ifc.in_valid = 1'b1; ifc.in_instr = 32'h00A00093 + 32'(k); ifc.in_pc = 32'h3000;
      tick();
    end
    check("preflush_count", 64'(count), 64'd3);
    flush = 1'b1; ifc.in_instr = 32'h00B50533; ifc.out_ready = 1'b1;
    tick();
    flush = 1'b0; ifc.in_valid = 1'b0; ifc.out_ready = 1'b0;
    #1;
    $display("flush count=%0d out_valid=%0d", count, ifc.out_valid);
    check("flush_count", 64'(count), 64'd0);
    check("flush_out_valid", 64'(ifc.out_valid), 64'd0);
    check("flush_out_instr", 64'(ifc.out_instr), 64'd0);
    tick();
    check("flush_offer_dropped", 64'(count), 64'd0);

    // Randomized traffic against the queue model.
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic [31:0] r;
      logic [6:0]  op;
      logic        exp_valid;
      logic        acc;
      r = $urandom();
      if ($urandom_range(0, 7) == 0) op = r[6:0];
      else op = ref_tab[$urandom_range(0, 18)].op;
      ifc.in_valid  = ($urandom_range(0, 99) < 60);
      ifc.in_instr  = {r[31:7], op};
      ifc.in_pc     = $urandom();
      ifc.out_ready = ($urandom_range(0, 99) < 50);
      fpu_busy      = ($urandom_range(0, 99) < 30);
      flush         = ($urandom_range(0, 99) < 4);
      #1;
      exp_valid = (mq.size() != 0) && !(mq[0].b[5] && fpu_busy);
      check("rnd_count", 64'(count), 64'(mq.size()));
      check("rnd_in_ready", 64'(ifc.in_ready), 64'(mq.size() != DEPTH));
      check("rnd_out_valid", 64'(ifc.out_valid), 64'(exp_valid));
      if (mq.size() != 0) begin
        check("rnd_bundle", 64'(act), 64'(mq[0].b));
        check("rnd_head", {ifc.out_instr, ifc.out_pc}, {mq[0].instr, mq[0].pc});
      end else begin
        check("rnd_empty_outputs", {11'd0, act, ifc.out_instr ^ ifc.out_pc}, 64'd0);
      end
      if (flush) begin
        $display("rnd %0d flush", cyc);
        mq.delete();
      end else begin
        acc = ifc.in_valid && (mq.size() != DEPTH);
        if (exp_valid && ifc.out_ready) begin
          $display("rnd %0d deq instr=%h", cyc, mq[0].instr);
          void'(mq.pop_front());
        end
        if (acc) begin
          $display("rnd %0d enq instr=%h", cyc, ifc.in_instr);
          mq.push_back('{ifc.in_instr, ifc.in_pc, ref_decode(ifc.in_instr, 1'b1, 1'b1)});
        end
      end
      @(posedge clk);
      #1;
    end
    idle_inputs();
    mq.delete();

    // Reset in the middle of operation discards queued entries.
    ifc.in_valid = 1'b1; ifc.in_instr = 32'h00B50533;
    tick(); tick();
    ifc.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    $display("midreset count=%0d out_valid=%0d", count, ifc.out_valid);
    check("midreset_count", 64'(count), 64'd0);
    check("midreset_out_valid", 64'(ifc.out_valid), 64'd0);
    check("midreset_in_ready", 64'(ifc.in_ready), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
